pwm_modulator: RTL

//  Fast-domain consumer of the 5-bit sample bus produced by the slow->fast clock-domain crossing.

---
 rtl/pwm_pkg.sv | 18 +
 rtl/pwm_deadtime.sv | 35 +++
 rtl/pwm_modulator.sv | 133 +++++++++++++
 3 files changed

// File: rtl/pwm_pkg.sv
// pwm_pkg: shared defaults and FSM state type for the PWM modulator slice.
//   PWM_DATA_W   - default sample/duty width
//   PWM_PERIOD   - default fast_clk cycles per PWM frame
//   PWM_DEADTIME - default dead-time cycles per edge (complementary build only)
//   pwm_state_t  - IDLE / RUN / DRAIN
package pwm_pkg;

    localparam int unsigned PWM_DATA_W   = 5;
    localparam int unsigned PWM_PERIOD   = 32;
    localparam int unsigned PWM_DEADTIME = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } pwm_state_t;

endpackage

// File: rtl/pwm_deadtime.sv
// pwm_deadtime: dead-time insertion for the complementary PWM pair.
// Keeps the previous DEADTIME values of the raw PWM stream; an output only
// asserts once raw has been stable at its level for DEADTIME+1 cycles.
// Ports:
//   fast_clk - clock, rising edge
//   reset    - synchronous, active-high; clears the history
//   raw      - registered raw compare result
//   busy     - modulator active (RUN/DRAIN); history is cleared while low
//   hi       - high-side output
//   lo       - low-side output, gated by busy
module pwm_deadtime #(
    parameter int unsigned DEADTIME = 2
) (
    input  logic fast_clk,
    input  logic reset,
    input  logic raw,
    input  logic busy,
    output logic hi,
    output logic lo
);

    logic [DEADTIME-1:0] hist;

    always_ff @(posedge fast_clk) begin
        if (reset || !busy) begin
            hist <= '0;
        end else begin
            hist <= DEADTIME'({hist, raw});
        end
    end

    assign hi = raw & (&hist);
    assign lo = ~raw & ~(|hist) & busy;

endmodule

// File: rtl/pwm_modulator.sv
// pwm_modulator: converts a quasi-static sample into fixed-period PWM frames.
// The sample is shadowed into duty_q only at frame boundaries; an
// IDLE/RUN/DRAIN FSM lets the stream start and stop on whole frames.
// Optional feature macro: PWM_COMPLEMENT_EN (adds pwm_n with dead time).
// Ports:
//   fast_clk     - sole clock, rising edge
//   reset        - synchronous, active-high
//   sample       - unsigned duty value
//   enable       - request PWM generation
//   pwm_out      - PWM output
//   pwm_n        - complementary output (PWM_COMPLEMENT_EN only)
//   period_start - pulse in the first cycle of each frame
//   busy         - high in RUN or DRAIN
//   duty         - duty value currently applied
module pwm_modulator
    import pwm_pkg::*;
#(
    parameter int unsigned DATA_W   = PWM_DATA_W,
    parameter int unsigned PERIOD   = PWM_PERIOD,
    parameter int unsigned DEADTIME = PWM_DEADTIME
) (
    input  logic              fast_clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] sample,
    input  logic              enable,
    output logic              pwm_out,
`ifdef PWM_COMPLEMENT_EN
    output logic              pwm_n,
`endif
    output logic              period_start,
    output logic              busy,
    output logic [DATA_W-1:0] duty
);

    localparam int unsigned CNT_W = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    // Wide enough that duty_q >= PERIOD always compares as "above every cnt".
    localparam int unsigned CMP_W = (DATA_W > CNT_W + 1) ? DATA_W : CNT_W + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PERIOD - 1);

    if (PERIOD < 2) begin : g_bad_period
        $error("pwm_modulator: PERIOD must be >= 2");
    end
    if (DEADTIME < 1 || 2 * DEADTIME >= PERIOD) begin : g_bad_deadtime
        $error("pwm_modulator: DEADTIME must satisfy 1 <= DEADTIME < PERIOD/2");
    end

    pwm_state_t        state, state_n;
    logic [CNT_W-1:0]  cnt, cnt_n, cnt_inc;
    logic [DATA_W-1:0] duty_q, duty_n;
    logic              wrap;
    logic              raw_n, raw_q;
    logic              start_n, start_q;

    assign wrap    = (cnt == LAST);
    assign cnt_inc = wrap ? '0 : cnt + CNT_W'(1);

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        duty_n  = duty_q;
        case (state)
            IDLE: begin
                if (enable) begin
                    state_n = RUN;
                    cnt_n   = '0;
                    duty_n  = sample;
                end
            end
            RUN: begin
                cnt_n = cnt_inc;
                if (wrap) begin
                    duty_n = sample;
                end
                if (!enable) begin
                    state_n = wrap ? IDLE : DRAIN;
                end
            end
            DRAIN: begin
                cnt_n = cnt_inc;
                if (enable) begin
                    state_n = RUN;
                end else if (wrap) begin
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // Outputs are registered from next-state values so that they line up
    // with cnt/duty_q in the same cycle.
    assign raw_n   = (state_n != IDLE) && (CMP_W'(cnt_n) < CMP_W'(duty_n));
    assign start_n = (state_n != IDLE) && (cnt_n == '0);

    always_ff @(posedge fast_clk) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= '0;
            duty_q  <= '0;
            raw_q   <= 1'b0;
            start_q <= 1'b0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            duty_q  <= duty_n;
            raw_q   <= raw_n;
            start_q <= start_n;
        end
    end

    assign busy         = (state != IDLE);
    assign period_start = start_q;
    assign duty         = duty_q;

`ifdef PWM_COMPLEMENT_EN
    pwm_deadtime #(
        .DEADTIME(DEADTIME)
    ) u_deadtime (
        .fast_clk(fast_clk),
        .reset   (reset),
        .raw     (raw_q),
        .busy    (busy),
        .hi      (pwm_out),
        .lo      (pwm_n)
    );
`else
    assign pwm_out = raw_q;
`endif

endmodule
